// File: rtl/riscv_instr_aligner_if.sv
// -----------------------------------------------------------------------------
// riscv_instr_aligner_if
// Handshake bundle between the fetch unit, the branch/trap redirect source,
// the instruction aligner and the decoder.
//
// Signal names are given from the aligner's point of view (i_ = into the
// aligner, o_ = out of the aligner).
//   i_fetch_valid / o_fetch_ready / i_fetch_data : fetch word handshake
//   i_redirect / i_redirect_pc                   : flush and restart request
//   o_instr_valid / i_instr_ready                : instruction handshake
//   o_instr / o_pc / o_compressed / o_misaligned : instruction payload
//
// Modports:
//   master : fetch unit + decoder + redirect source side
//   slave  : the aligner
// -----------------------------------------------------------------------------
interface riscv_instr_aligner_if #(
   parameter int DataWidth = 32
);
   logic                 i_fetch_valid;
   logic                 o_fetch_ready;
   logic [31:0]          i_fetch_data;
   logic                 i_redirect;
   logic [DataWidth-1:0] i_redirect_pc;
   logic                 o_instr_valid;
   logic                 i_instr_ready;
   logic [31:0]          o_instr;
   logic [DataWidth-1:0] o_pc;
   logic                 o_compressed;
   logic                 o_misaligned;

   modport master (
      output i_fetch_valid,
      output i_fetch_data,
      output i_redirect,
      output i_redirect_pc,
      output i_instr_ready,
      input  o_fetch_ready,
      input  o_instr_valid,
      input  o_instr,
      input  o_pc,
      input  o_compressed,
      input  o_misaligned
   );

   modport slave (
      input  i_fetch_valid,
      input  i_fetch_data,
      input  i_redirect,
      input  i_redirect_pc,
      input  i_instr_ready,
      output o_fetch_ready,
      output o_instr_valid,
      output o_instr,
      output o_pc,
      output o_compressed,
      output o_misaligned
   );
endinterface

// File: rtl/riscv_instr_aligner.sv
// -----------------------------------------------------------------------------
// riscv_instr_aligner
// Sits between instruction fetch and the decoder. Sequential 32-bit fetch words
// are split into halfwords and held in a 4-entry buffer (hb[0] is the head).
// One instruction is extracted per decoder handshake: 16-bit compressed or
// 32-bit, including 32-bit instructions straddling two fetch words.
//
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high (wins over redirect)
//   bus  : riscv_instr_aligner_if.slave (fetch, redirect, instruction handshakes)
//
// Parameters:
//   DataWidth : PC width
//   ResetPc   : PC of the first instruction after reset
//
// Build option:
//   RVC_EN defined   : compressed instructions supported, o_misaligned tied 0.
//   RVC_EN undefined : every instruction is 32-bit; a redirect to a
//                      halfword-aligned PC raises a sticky misaligned error that
//                      holds o_instr_valid=1, o_instr=0 and blocks fetch until
//                      the next redirect or reset.
// -----------------------------------------------------------------------------
module riscv_instr_aligner #(
   parameter int                   DataWidth = 32,
   parameter logic [DataWidth-1:0] ResetPc   = '0
) (
   input logic                    clk,
   input logic                    rst,
   riscv_instr_aligner_if.slave   bus
);

   logic [15:0]          r_hb [4];
   logic [2:0]           r_cnt;
   logic [DataWidth-1:0] r_pc;
   logic                 r_drop;
   logic                 r_err;

   logic                 w_comp;
   logic                 w_mis_redirect;
   logic                 w_fetch_ready;
   logic                 w_instr_valid;
   logic                 w_accept;
   logic                 w_fire;
   logic [1:0]           w_consumed;
   logic [2:0]           w_appended;
   logic [2:0]           w_cnt_mid;
   logic [2:0]           w_cnt_nxt;
   logic [1:0]           w_wr0;
   logic [1:0]           w_wr1;
   logic [15:0]          w_hb_nxt [4];
   logic [DataWidth-1:0] w_pc_inc;
   logic                 w_unused;

   // Redirect PC bit 0 is architecturally always zero and is ignored.
   assign w_unused = bus.i_redirect_pc[0];

`ifdef RVC_EN
   assign w_comp         = (r_hb[0][1:0] != 2'b11);
   assign w_mis_redirect = 1'b0;
`else
   // Without the C extension everything is 32-bit, even heads whose low bits
   // would mark them compressed; the decoder rejects those as illegal.
   assign w_comp         = 1'b0;
   assign w_mis_redirect = bus.i_redirect_pc[1];
`endif

   assign w_fetch_ready = (r_cnt <= 3'd2) && !r_err;
   assign w_instr_valid = r_err || (r_cnt >= 3'd2) || ((r_cnt >= 3'd1) && w_comp);

   // The sticky error is presented to the decoder but never consumed.
   assign w_accept = bus.i_fetch_valid && w_fetch_ready;
   assign w_fire   = w_instr_valid && bus.i_instr_ready && !r_err;

   assign w_consumed = !w_fire ? 2'd0 : (w_comp ? 2'd1 : 2'd2);
   assign w_appended = !w_accept ? 3'd0 : (r_drop ? 3'd1 : 3'd2);

   // Consumption happens before append; accept only when cnt<=2 keeps the
   // sum within the 4 entries.
   assign w_cnt_mid = r_cnt - {1'b0, w_consumed};
   assign w_cnt_nxt = w_cnt_mid + w_appended;
   assign w_wr0     = w_cnt_mid[1:0];
   assign w_wr1     = w_wr0 + 2'd1;

   assign w_pc_inc = {{(DataWidth-3){1'b0}}, w_consumed, 1'b0};

   always_comb begin
      w_hb_nxt = r_hb;
      case (w_consumed)
         2'd1: begin
            w_hb_nxt[0] = r_hb[1];
            w_hb_nxt[1] = r_hb[2];
            w_hb_nxt[2] = r_hb[3];
            w_hb_nxt[3] = 16'h0000;
         end
         2'd2: begin
            w_hb_nxt[0] = r_hb[2];
            w_hb_nxt[1] = r_hb[3];
            w_hb_nxt[2] = 16'h0000;
            w_hb_nxt[3] = 16'h0000;
         end
         default: ;
      endcase
      if (w_accept) begin
         if (r_drop) begin
            // Restart landed on the upper halfword of this word.
            w_hb_nxt[w_wr0] = bus.i_fetch_data[31:16];
         end else begin
            w_hb_nxt[w_wr0] = bus.i_fetch_data[15:0];
            w_hb_nxt[w_wr1] = bus.i_fetch_data[31:16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hb   <= '{default: 16'h0000};
         r_cnt  <= 3'd0;
         r_pc   <= ResetPc;
         r_drop <= 1'b0;
         r_err  <= 1'b0;
      end else if (bus.i_redirect) begin
         r_hb   <= '{default: 16'h0000};
         r_cnt  <= 3'd0;
         r_pc   <= {bus.i_redirect_pc[DataWidth-1:1], 1'b0};
         r_drop <= bus.i_redirect_pc[1];
         r_err  <= w_mis_redirect;
      end else begin
         r_hb  <= w_hb_nxt;
         r_cnt <= w_cnt_nxt;
         r_pc  <= r_pc + w_pc_inc;
         if (w_accept) begin
            r_drop <= 1'b0;
         end
      end
   end

   assign bus.o_fetch_ready = w_fetch_ready;
   assign bus.o_instr_valid = w_instr_valid;
   assign bus.o_pc          = r_pc;
   // Qualified by occupancy so an empty (zeroed) buffer is not reported as RVC.
   assign bus.o_compressed  = w_comp && (r_cnt != 3'd0);
   assign bus.o_misaligned  = r_err;
   assign bus.o_instr       = r_err  ? 32'h0000_0000 :
                              w_comp ? {16'h0000, r_hb[0]} :
                                       {r_hb[1], r_hb[0]};

endmodule

// File: tb/tb_riscv_instr_aligner.sv
module tb_riscv_instr_aligner;

   localparam int          DW       = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_instr_aligner_if #(.DataWidth(DW)) bus ();

   riscv_instr_aligner #(
      .DataWidth (DW),
      .ResetPc   (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   exp_t        exp_q[$];
   logic [15:0] pend_q[$];
   logic [31:0] src_q[$];
   logic [31:0] m_pc;
   logic        m_drop;
   logic        m_err;
   int          m_cnt;

   // Scoreboard: reference halfword parser fed by accepted fetch words,
   // checked against every instruction handshake.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] h;
      if (rst) begin
         exp_q.delete();
         pend_q.delete();
         m_pc   = RESET_PC;
         m_drop = 1'b0;
         m_err  = 1'b0;
         m_cnt  = 0;
      end else begin
         tests_run++;
         if (bus.o_instr_valid !== (m_err || exp_q.size() != 0)) begin
            tests_failed++;
            $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, bus.o_instr_valid, (m_err || exp_q.size() != 0));
         end
         tests_run++;
         if (bus.o_fetch_ready !== (!m_err && m_cnt <= 2)) begin
            tests_failed++;
            $display("FAIL sb_fetch_ready t=%0t got=%b exp=%b", $time, bus.o_fetch_ready, (!m_err && m_cnt <= 2));
         end
         tests_run++;
         if (bus.o_misaligned !== m_err) begin
            tests_failed++;
            $display("FAIL sb_misaligned t=%0t got=%b exp=%b", $time, bus.o_misaligned, m_err);
         end
         if (bus.i_redirect) begin
            exp_q.delete();
            pend_q.delete();
            m_pc   = {bus.i_redirect_pc[31:1], 1'b0};
            m_drop = bus.i_redirect_pc[1];
            m_err  = !RVC && bus.i_redirect_pc[1];
            m_cnt  = 0;
         end else begin
            if (bus.o_instr_valid && bus.i_instr_ready && !m_err) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL sb_unexpected_instr t=%0t got=%h pc=%h exp=none", $time, bus.o_instr, bus.o_pc);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.o_instr !== e.instr || bus.o_pc !== e.pc || bus.o_compressed !== e.comp) begin
                     tests_failed++;
                     $display("FAIL sb_instr t=%0t got=%h/%h/%b exp=%h/%h/%b", $time,
                              bus.o_instr, bus.o_pc, bus.o_compressed, e.instr, e.pc, e.comp);
                  end
                  m_cnt -= e.comp ? 1 : 2;
               end
            end
            if (bus.i_fetch_valid && bus.o_fetch_ready) begin
               if (!m_drop) begin
                  pend_q.push_back(bus.i_fetch_data[15:0]);
                  m_cnt++;
               end
               pend_q.push_back(bus.i_fetch_data[31:16]);
               m_cnt++;
               m_drop = 1'b0;
               while (pend_q.size() > 0) begin
                  h = pend_q[0];
                  if (RVC && h[1:0] != 2'b11) begin
                     exp_q.push_back('{{16'h0000, h}, m_pc, 1'b1});
                     m_pc = m_pc + 32'd2;
                     void'(pend_q.pop_front());
                  end else if (pend_q.size() >= 2) begin
                     exp_q.push_back('{{pend_q[1], pend_q[0]}, m_pc, 1'b0});
                     m_pc = m_pc + 32'd4;
                     void'(pend_q.pop_front());
                     void'(pend_q.pop_front());
                  end else begin
                     break;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_fetch_valid = 1'b0;
      bus.i_fetch_data  = 32'h0;
      bus.i_instr_ready = 1'b0;
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = '0;
   endtask

   // Feed src_q to the DUT and consume until both source and scoreboard drain.
   task automatic drain(input int rdy_pct, input int fv_pct, input int budget);
      int n = 0;
      bit acc;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         bus.i_fetch_valid = (src_q.size() > 0) && ($urandom_range(0, 99) < fv_pct);
         bus.i_fetch_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
         bus.i_instr_ready = ($urandom_range(0, 99) < rdy_pct);
         acc = bus.i_fetch_valid && bus.o_fetch_ready;
         tick();
         if (acc) void'(src_q.pop_front());
         n++;
      end
      idle();
      tests_run++;
      if (src_q.size() != 0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain_timeout src_left=%0d exp_left=%0d required=0/0", src_q.size(), exp_q.size());
         src_q.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      tests_run++;
      if (bus.o_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.o_instr_valid); end
      tests_run++;
      if (bus.o_fetch_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_fetch_ready got=%b exp=1", bus.o_fetch_ready); end
      tests_run++;
      if (bus.o_pc !== RESET_PC) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", bus.o_pc, RESET_PC); end
      tests_run++;
      if (bus.o_compressed !== 1'b0) begin tests_failed++; $display("FAIL reset_compressed got=%b exp=0", bus.o_compressed); end
      tests_run++;
      if (bus.o_misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned got=%b exp=0", bus.o_misaligned); end
      tests_run++;
      if (bus.o_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got=%h exp=0", bus.o_instr); end
      rst = 1'b0;
   endtask

   task automatic test_basic_latency();
      bus.i_instr_ready = 1'b0;
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'h00A00093;
      tests_run++;
      if (bus.o_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_pre_valid got=%b exp=0", bus.o_instr_valid); end
      tick();
      bus.i_fetch_valid = 1'b0;
      tests_run++;
      if (bus.o_instr_valid !== 1'b1 || bus.o_instr !== 32'h00A00093 || bus.o_pc !== 32'h0 || bus.o_compressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL lat_first got=%b/%h/%h/%b exp=1/00a00093/00000000/0",
                  bus.o_instr_valid, bus.o_instr, bus.o_pc, bus.o_compressed);
      end
      src_q.push_back(32'h00108113);
      drain(100, 100, 50);
      tests_run++;
      if (bus.o_pc !== 32'h8) begin tests_failed++; $display("FAIL lat_final_pc got=%h exp=00000008", bus.o_pc); end
   endtask

   task automatic test_random_stream();
      for (int i = 0; i < 40; i++) src_q.push_back($urandom);
      drain(60, 70, 3000);
   endtask

   task automatic test_backpressure();
      bit acc;
      for (int i = 0; i < 8; i++) src_q.push_back($urandom);
      bus.i_instr_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         bus.i_fetch_valid = 1'b1;
         bus.i_fetch_data  = src_q[0];
         acc = bus.o_fetch_ready;
         tick();
         if (acc) void'(src_q.pop_front());
      end
      bus.i_fetch_valid = 1'b0;
      tests_run++;
      if (bus.o_fetch_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready got=%b exp=0", bus.o_fetch_ready); end
      tests_run++;
      if (bus.o_instr_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_full_valid got=%b exp=1", bus.o_instr_valid); end
      drain(100, 100, 200);
   endtask

   task automatic test_redirect();
      for (int i = 0; i < 3; i++) src_q.push_back(32'h00108113 + 32'(i << 20));
      bus.i_instr_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.i_fetch_valid = 1'b1;
         bus.i_fetch_data  = src_q[0];
         if (bus.o_fetch_ready) begin
            tick();
            void'(src_q.pop_front());
         end else begin
            tick();
         end
      end
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'h0000_0101;
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'hDEADBEEF;
      bus.i_instr_ready = 1'b1;
      tick();
      idle();
      src_q.delete();
      tests_run++;
      if (bus.o_instr_valid !== 1'b0 || bus.o_pc !== 32'h100 || bus.o_fetch_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL redir_state got=%b/%h/%b exp=0/00000100/1", bus.o_instr_valid, bus.o_pc, bus.o_fetch_ready);
      end
      src_q.push_back(32'h00A00093);
      src_q.push_back(32'h00108113);
      drain(100, 100, 100);
      tests_run++;
      if (bus.o_pc !== 32'h108) begin tests_failed++; $display("FAIL redir_final_pc got=%h exp=00000108", bus.o_pc); end
   endtask

`ifndef RVC_EN
   task automatic test_misaligned();
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'h0000_0006;
      tick();
      idle();
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (bus.o_instr_valid !== 1'b1 || bus.o_misaligned !== 1'b1 || bus.o_instr !== 32'h0 ||
             bus.o_pc !== 32'h6 || bus.o_fetch_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_sticky cyc=%0d got=%b/%b/%h/%h/%b exp=1/1/00000000/00000006/0", c,
                     bus.o_instr_valid, bus.o_misaligned, bus.o_instr, bus.o_pc, bus.o_fetch_ready);
         end
         bus.i_fetch_valid = 1'b1;
         bus.i_fetch_data  = 32'h00A00093;
         bus.i_instr_ready = 1'b1;
         tick();
      end
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'h0000_0008;
      tick();
      idle();
      tests_run++;
      if (bus.o_misaligned !== 1'b0 || bus.o_instr_valid !== 1'b0 || bus.o_fetch_ready !== 1'b1 || bus.o_pc !== 32'h8) begin
         tests_failed++;
         $display("FAIL mis_clear got=%b/%b/%b/%h exp=0/0/1/00000008",
                  bus.o_misaligned, bus.o_instr_valid, bus.o_fetch_ready, bus.o_pc);
      end
      src_q.push_back(32'h4501_4581);
      drain(100, 100, 50);
   endtask
`else
   task automatic test_rvc_pair();
      do_reset();
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'h45814501;
      tick();
      bus.i_fetch_valid = 1'b0;
      tests_run++;
      if (bus.o_instr !== 32'h00004501 || bus.o_pc !== 32'h0 || bus.o_compressed !== 1'b1) begin
         tests_failed++;
         $display("FAIL rvc_pair_first got=%h/%h/%b exp=00004501/00000000/1", bus.o_instr, bus.o_pc, bus.o_compressed);
      end
      drain(100, 100, 20);
   endtask

   task automatic test_rvc_straddle();
      do_reset();
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'h00934505;
      tick();
      bus.i_fetch_valid = 1'b0;
      bus.i_instr_ready = 1'b1;
      tick();
      bus.i_instr_ready = 1'b0;
      tests_run++;
      if (bus.o_instr_valid !== 1'b0 || bus.o_pc !== 32'h2) begin
         tests_failed++;
         $display("FAIL rvc_straddle_hold got=%b/%h exp=0/00000002", bus.o_instr_valid, bus.o_pc);
      end
      src_q.push_back(32'h410000A0);
      drain(100, 100, 20);
   endtask

   task automatic test_rvc_redirect_drop();
      bus.i_instr_ready = 1'b0;
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'h00A00093;
      tick();
      bus.i_fetch_data  = 32'h00000013;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'h0000_0102;
      tick();
      idle();
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'hAAAA4505;
      tick();
      bus.i_fetch_valid = 1'b0;
      tests_run++;
      if (bus.o_instr !== 32'h0000AAAA || bus.o_pc !== 32'h102 || bus.o_compressed !== 1'b1) begin
         tests_failed++;
         $display("FAIL rvc_drop got=%h/%h/%b exp=0000aaaa/00000102/1", bus.o_instr, bus.o_pc, bus.o_compressed);
      end
      drain(100, 100, 20);
   endtask
`endif

   task automatic test_pc_wrap();
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'hFFFF_FFFC;
      tick();
      idle();
      src_q.push_back(32'h00A00093);
      src_q.push_back(32'h00108113);
      drain(100, 100, 50);
      tests_run++;
      if (bus.o_pc !== 32'h4) begin tests_failed++; $display("FAIL wrap_pc got=%h exp=00000004", bus.o_pc); end
   endtask

   task automatic test_rst_priority();
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_data  = 32'h00A00093;
      tick();
      rst               = 1'b1;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 32'h0000_0200;
      tick();
      rst = 1'b0;
      idle();
      tests_run++;
      if (bus.o_pc !== RESET_PC || bus.o_instr_valid !== 1'b0 || bus.o_fetch_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_priority got=%h/%b/%b exp=%h/0/1", bus.o_pc, bus.o_instr_valid, bus.o_fetch_ready, RESET_PC);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_basic_latency();
      test_random_stream();
      test_backpressure();
      test_redirect();
`ifndef RVC_EN
      test_misaligned();
`else
      test_rvc_pair();
      test_rvc_straddle();
      test_rvc_redirect_drop();
`endif
      test_pc_wrap();
      test_rst_priority();
      src_q.push_back(32'h00A00093);
      drain(100, 100, 20);
      tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
